// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rect_fill
//  Description : Avalon-MM write initiator that fills an axis-aligned
//                rectangle of the VGA frame buffer with one colour, one
//                pixel word per transfer, walking the rectangle row by row.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_fill #(
  parameter int AVN_AW    = 19,
  parameter int AVN_DW    = 16,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BASE_ADDR = 0,
  parameter int XW        = $clog2(H_RES),
  parameter int YW        = $clog2(V_RES)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [XW-1:0]         cmd_x0,
  input  logic [XW-1:0]         cmd_x1,
  input  logic [YW-1:0]         cmd_y0,
  input  logic [YW-1:0]         cmd_y1,
  input  logic [AVN_DW-1:0]     cmd_color,
  input  logic                  cmd_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err,
  output logic                  framebuffer_avn_write,
  output logic                  framebuffer_avn_read,
  output logic [AVN_AW-1:0]     framebuffer_avn_address,
  output logic [AVN_DW-1:0]     framebuffer_avn_writedata,
  output logic [AVN_DW/8-1:0]   framebuffer_avn_byteenable,
  input  logic                  framebuffer_avn_waitrequest
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Limits carry one extra bit so a resolution equal to a power of two still fits.
  localparam logic [XW:0]       C_H_LIM = (XW+1)'(H_RES);
  localparam logic [YW:0]       C_V_LIM = (YW+1)'(V_RES);
  localparam logic [AVN_AW-1:0] C_PITCH = AVN_AW'(H_RES);
  localparam logic [AVN_AW-1:0] C_BASE  = AVN_AW'(BASE_ADDR);

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0]     y_q, y_d, y1_q, y1_d;
  logic [AVN_AW-1:0] row_base_q, row_base_d;
  logic [AVN_DW-1:0] color_q, color_d;
  logic              abort_q, abort_d;
  logic              aborted_q, aborted_d;
  logic              err_q, err_d;

  logic              legal;
  logic              cmd_fire;
  logic              beat;
  logic              row_end;
  logic              last_pixel;
  logic              abort_now;
  logic [AVN_AW-1:0] row0_base;

  assign legal      = (cmd_x0 <= cmd_x1) && ({1'b0, cmd_x1} < C_H_LIM) &&
                      (cmd_y0 <= cmd_y1) && ({1'b0, cmd_y1} < C_V_LIM);
  assign cmd_fire   = (state_q == S_IDLE) && cmd_valid;
  assign beat       = (state_q == S_WRITE) && !framebuffer_avn_waitrequest;
  assign row_end    = (x_q == x1_q);
  assign last_pixel = row_end && (y_q == y1_q);
  // A pending abort includes one raised in the very cycle a beat completes.
  assign abort_now  = abort_q | cmd_abort;
  // The only multiply: first row base, formed once when the command is taken.
  assign row0_base  = C_BASE + AVN_AW'(cmd_y0) * C_PITCH;

  // State register; reset returns to IDLE at once, dropping any write request.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: leave WRITE only when a beat is actually accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire && legal) state_d = S_WRITE;
      S_WRITE: if (beat && (last_pixel || abort_now)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    cmd_ready             = 1'b0;
    busy                  = 1'b0;
    done                  = 1'b0;
    framebuffer_avn_write = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_WRITE: begin
        busy                  = 1'b1;
        framebuffer_avn_write = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Rectangle walker: command latch, x/y stepping and row base accumulation.
  always_comb begin
    x_d        = x_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y_d        = y_q;
    y1_d       = y1_q;
    row_base_d = row_base_q;
    color_d    = color_q;
    abort_d    = abort_q;
    aborted_d  = aborted_q;
    err_d      = cmd_fire && !legal;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire && legal) begin
          x0_d       = cmd_x0;
          x1_d       = cmd_x1;
          x_d        = cmd_x0;
          y_d        = cmd_y0;
          y1_d       = cmd_y1;
          color_d    = cmd_color;
          row_base_d = row0_base;
          abort_d    = 1'b0;
          aborted_d  = 1'b0;
        end
      end
      S_WRITE: begin
        abort_d = abort_now;
        if (beat) begin
          aborted_d = abort_now;
          if (!row_end) begin
            x_d = x_q + 1'b1;
          end else if (!last_pixel) begin
            x_d        = x0_q;
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + C_PITCH;
          end
        end
      end
      S_DONE:  abort_d = 1'b0;
      default: abort_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_q        <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y_q        <= '0;
      y1_q       <= '0;
      row_base_q <= '0;
      color_q    <= '0;
      abort_q    <= 1'b0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y_q        <= y_d;
      y1_q       <= y1_d;
      row_base_q <= row_base_d;
      color_q    <= color_d;
      abort_q    <= abort_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
    end
  end

  assign aborted                    = done & aborted_q;
  assign err                        = err_q;
  assign framebuffer_avn_read       = 1'b0;
  assign framebuffer_avn_address    = row_base_q + AVN_AW'(x_q);
  assign framebuffer_avn_writedata  = color_q;
  assign framebuffer_avn_byteenable = '1;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rect_fill
//  Description : Self-checking bench for vga_rect_fill against a raster-order
//                address-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_fill;
  localparam int AW = 19, DW = 16, HR = 640, VR = 480, BASE = 0;
  localparam int XW = $clog2(HR), YW = $clog2(VR);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_abort = 1'b0, wreq = 1'b0;
  logic [XW-1:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [YW-1:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [DW-1:0] cmd_color = '0;
  logic          cmd_ready, busy, done, aborted, err, wr, rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] be;

  vga_rect_fill #(.AVN_AW(AW), .AVN_DW(DW), .H_RES(HR), .V_RES(VR), .BASE_ADDR(BASE)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_abort(cmd_abort),
    .busy(busy), .done(done), .aborted(aborted), .err(err),
    .framebuffer_avn_write(wr), .framebuffer_avn_read(rd),
    .framebuffer_avn_address(addr), .framebuffer_avn_writedata(wdata),
    .framebuffer_avn_byteenable(be), .framebuffer_avn_waitrequest(wreq)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, wr_cycles = 0;
  int log_q[$];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 writing, 2 done; the pending pixel addresses
  // of the accepted rectangle are kept as a raster-order list.
  int  phase = 0, m_color = 0;
  int  exp_q[$];
  bit  m_abort = 0, m_aborted = 0, m_err = 0;

  function automatic bit legal(input int x0, x1, y0, y1);
    return (x0 <= x1) && (x1 < HR) && (y0 <= y1) && (y1 < VR);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; exp_q.delete(); m_err = 0; m_abort = 0; m_aborted = 0;
    end else begin
      m_err = (phase == 0) && cmd_valid &&
              !legal(int'(cmd_x0), int'(cmd_x1), int'(cmd_y0), int'(cmd_y1));
      case (phase)
        0: if (cmd_valid && legal(int'(cmd_x0), int'(cmd_x1), int'(cmd_y0), int'(cmd_y1))) begin
          exp_q.delete();
          for (int y = int'(cmd_y0); y <= int'(cmd_y1); y++)
            for (int x = int'(cmd_x0); x <= int'(cmd_x1); x++)
              exp_q.push_back(BASE + y * HR + x);
          m_color = int'(cmd_color); m_abort = 0; m_aborted = 0; phase = 1;
        end
        1: begin
          m_abort = m_abort | cmd_abort;
          if (!wreq) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0 || m_abort) begin m_aborted = m_abort; phase = 2; end
          end
        end
        default: phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, mid-cycle.
  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, phase == 0);
    chk("busy", busy, phase != 0);
    chk("write", wr, phase == 1);
    chk("done", done, phase == 2);
    chk("aborted", aborted, (phase == 2) && m_aborted);
    chk("err", err, m_err);
    chk("read", rd, 0);
    chk("byteenable", be, 2'b11);
    if (phase == 1 && exp_q.size() > 0) begin
      chk("address", addr, exp_q[0]);
      chk("writedata", wdata, m_color);
    end
    if (wr) wr_cycles++;
    if (wr && !wreq) log_q.push_back(int'(addr));
  end

  // waitrequest driver: 0 = never stall, 1 = random, 2 = window [wr_lo, wr_hi].
  int wr_mode = 0, wr_lo = 1, wr_hi = 0;
  always @(posedge clk) begin
    #2;
    case (wr_mode)
      1:       wreq = ($urandom_range(0, 3) == 0);
      2:       wreq = (cyc >= wr_lo) && (cyc <= wr_hi);
      default: wreq = 1'b0;
    endcase
  end

  task automatic issue(input int x0, x1, y0, y1, input int col, output int t);
    @(posedge clk); #2;
    cmd_x0 = x0[XW-1:0]; cmd_x1 = x1[XW-1:0];
    cmd_y0 = y0[YW-1:0]; cmd_y1 = y1[YW-1:0];
    cmd_color = col[DW-1:0]; cmd_valid = 1'b1; t = cyc;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int t, input int lat, input bit ab, input bit noise, input string nm);
    int n = 0;
    do begin
      @(negedge clk); n++;
      if (!done && noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_x0 = '0; cmd_x1 = XW'($urandom_range(0, HR - 1));
        cmd_y0 = '0; cmd_y1 = YW'($urandom_range(0, VR - 1));
      end
    end while (!done && n < 20000);
    cmd_valid = 1'b0;
    if (!done) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      if (lat >= 0) chk({nm, "_latency"}, cyc - t, lat);
      chk({nm, "_aborted"}, aborted, ab);
    end
  endtask

  task automatic chk_log(input string nm, input int start, input int exp[$]);
    chk({nm, "_count"}, log_q.size() - start, exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk({nm, "_addr"}, (start + i < log_q.size()) ? log_q[start + i] : -1, exp[i]);
  endtask

  initial begin
    int t, s, w0, bad;
    int x0, x1, y0, y1;
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_write", wr, 0); chk("rst_address", addr, 0);
    chk("rst_writedata", wdata, 0); chk("rst_byteenable", be, 2'b11);
    @(posedge clk); #2; rst_n = 1'b1;

    // 3x2 fill, no stalls.
    s = log_q.size();
    issue(2, 4, 1, 2, 'hF800, t);
    wait_done(t, 7, 0, 0, "fill1");
    chk_log("fill1", s, '{642, 643, 644, 1282, 1283, 1284});

    // Same fill, second beat stalled for 3 cycles.
    wr_mode = 2; s = log_q.size(); w0 = wr_cycles;
    issue(2, 4, 1, 2, 'h07E0, t);
    wr_lo = t + 2; wr_hi = t + 4;
    wait_done(t, 10, 0, 0, "stall");
    chk_log("stall", s, '{642, 643, 644, 1282, 1283, 1284});
    chk("stall_write_cycles", wr_cycles - w0, 9);
    wr_mode = 0;

    // Illegal commands.
    s = log_q.size();
    issue(5, 4, 0, 0, 'h1234, t);
    @(negedge clk);
    chk("err_x_pulse", err, 1); chk("err_x_ready", cmd_ready, 1);
    issue(0, 0, 0, 480, 'h1234, t);
    @(negedge clk);
    chk("err_y_pulse", err, 1);
    repeat (3) @(posedge clk);
    chk("err_no_writes", log_q.size() - s, 0);

    // Abort raised while the 4th beat is stalled.
    wr_mode = 2; s = log_q.size();
    issue(0, 9, 0, 9, 'hABCD, t);
    wr_lo = t + 4; wr_hi = t + 5;
    repeat (3) @(posedge clk);
    #2; cmd_abort = 1'b1;
    @(posedge clk); #2; cmd_abort = 1'b0;
    wait_done(t, 7, 1, 0, "abort");
    chk_log("abort", s, '{0, 1, 2, 3});
    wr_mode = 0;

    // Random rectangles with random stalls and ignored commands while busy.
    wr_mode = 1;
    for (int k = 0; k < 24; k++) begin
      x0 = $urandom_range(0, HR - 1); x1 = x0 + $urandom_range(0, 15);
      y0 = $urandom_range(0, VR - 1); y1 = y0 + $urandom_range(0, 6);
      if (x1 > HR - 1) x1 = HR - 1;
      if (y1 > VR - 1) y1 = VR - 1;
      if ($urandom_range(0, 4) == 0) y1 = VR + $urandom_range(0, 31);
      if (legal(x0, x1, y0, y1)) begin
        issue(x0, x1, y0, y1, $urandom_range(0, 65535), t);
        wait_done(t, -1, 0, 1, "rand");
      end else begin
        issue(x0, x1, y0, y1, 0, t);
        repeat (2) @(posedge clk);
      end
    end

    // Bottom ten full rows, reaching the last frame word.
    s = log_q.size();
    issue(0, HR - 1, VR - 10, VR - 1, 'h5A5A, t);
    wait_done(t, -1, 0, 1, "big");
    chk("big_count", log_q.size() - s, 6400);
    chk("big_first", (log_q.size() > s) ? log_q[s] : -1, 300800);
    chk("big_last", log_q[log_q.size() - 1], 307199);
    bad = 0;
    for (int i = s + 1; i < log_q.size(); i++) if (log_q[i] != log_q[i - 1] + 1) bad++;
    chk("big_order", bad, 0);
    wr_mode = 0;

    // Reset in the middle of a row.
    issue(0, HR - 1, 5, 5, 'hFFFF, t);
    repeat (100) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("midrst_write", wr, 0); chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", cmd_ready, 1);
    s = log_q.size();
    issue(HR - 1, HR - 1, VR - 1, VR - 1, 'h0F0F, t);
    wait_done(t, 2, 0, 0, "corner");
    chk_log("corner", s, '{307199});

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
